serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial addition controller that time-shares one external full_adder instance across a WIDTH-bit operation, one bit per clock, LSB first. It latches operands on a valid/ready handshake, drives the full adder's a/b/cin each cycle, registers its carry back, and shifts sum bits into a result register. It sits between a requester and a single full_adder cell so that multi-bit addition costs one adder plus registers.

Parameters:
WIDTH, 8, operand and result width in bits (2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  requester presents operands
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in for bit 0, sampled on accept
fa_a  output  1  to full_adder a: current bit of A shift register
fa_b  output  1  to full_adder b: current bit of B shift register
fa_cin  output  1  to full_adder cin: registered carry
fa_sum  input  1  from full_adder sum
fa_carry  input  1  from full_adder carry
out_valid  output  1  result available
out_ready  input  1  consumer takes result
sum  output  WIDTH  result
cout  output  1  carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk. Reset synchronous, active-low on rst_n; sampled only on the rising edge of clk.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry reg=0, bit counter=0, fa_a/fa_b/fa_cin=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. Accept when in_valid&&in_ready. On accept, load a_sh=a, b_sh=b, carry=cin, cnt=0, sum=0, then go to RUN.
- RUN, WIDTH cycles:
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry (combinational from registers).
  - Each edge: carry<=fa_carry; sum<={fa_sum,sum[WIDTH-1:1]}; a_sh,b_sh shift right by 1; cnt<=cnt+1.
  - When cnt==WIDTH-1, go to DONE and set cout<=fa_carry.
- DONE: out_valid=1; sum/cout held stable. When out_ready=1, go to IDLE on the next edge.
- Latency: accept edge at cycle 0. out_valid rises after edge WIDTH, so it is visible during cycle WIDTH+1. Minimum throughput is one add per WIDTH+2 cycles.
- Outside RUN: fa_a/fa_b/fa_cin=0.
- cnt width is clog2(WIDTH)+1. There is no wrap inside RUN.
- in_valid while busy: ignored (in_ready=0). Operands are not queued.
- out_ready asserted while not in DONE: no effect.
- out_ready held low in DONE: stay in DONE indefinitely with outputs stable.
- Reset mid-RUN or mid-DONE: returns to the reset values on that edge. The partial result is discarded and out_valid never pulses.
- sum/cout keep their last value in IDLE until the next accept clears sum.
- Assertion: in RUN, fa_sum must equal fa_a^fa_b^fa_cin.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit). In RUN at cnt==WIDTH-1, capture ovf<=carry^fa_carry (carry into MSB XOR carry out of MSB), which is two's-complement signed overflow. ovf is valid with out_valid, reset to 0, and cleared on accept.
- Undefined: no ovf port and no extra register. The port list is exactly as above.

Test Plan:
- WIDTH=8; a=0x0F, b=0x01, cin=0 accepted at cycle 0 -> out_valid first seen in cycle 9, sum=0x10, cout=0; in_ready=0 for cycles 1..9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Check fa_cin each RUN cycle matches the expected ripple carry.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0. a=0x80, b=0xFF -> sum=0x7F, ovf=1, cout=1. a=0x05, b=0x03 -> ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout remain constant. Pulse in_valid with a=0x11 during that time -> not accepted (in_ready=0). After out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset: drive rst_n=0 at cycle 4 of RUN (a=0xAA, b=0x55) -> next edge state=IDLE, out_valid=0, sum=0, cout=0. A new accept of a=0x03, b=0x04 gives sum=0x07 with no residue from the aborted operation.
- Random: 500 back-to-back operations with random a/b/cin, in_valid and out_ready -> each result equals {cout,sum}=a+b+cin against a scoreboard. A behavioural full_adder model must always satisfy the RUN-state assertion.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller sharing one external full_adder, LSB first.
// Optional SERIAL_ADD_OVF_EN adds an ovf output flagging two's-complement overflow.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0] cnt;
    logic carry;
    logic last;
    assign last = cnt == CW'(WIDTH - 1);
    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    // next-state: accept in IDLE, WIDTH bit steps in RUN, hold DONE until consumed
    always_comb begin
        state_n = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                  (state == RUN)  ? (last ? DONE : RUN) :
                                    (out_ready ? IDLE : DONE);
    end
    // outputs decoded from state; adder inputs are forced low outside RUN
    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        fa_a      = (state == RUN) ? a_sh[0] : 1'b0;
        fa_b      = (state == RUN) ? b_sh[0] : 1'b0;
        fa_cin    = (state == RUN) ? carry : 1'b0;
    end
    // datapath: load on accept, then shift one sum bit in per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == RUN) begin
            carry <= fa_carry;
            sum   <= {fa_sum, sum[WIDTH-1:1]};
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout <= fa_carry;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry ^ fa_carry;
`endif
            end
        end
    end
    // the external cell must behave as a full adder while it is in use
    a_fa_sum: assert property (@(posedge clk) disable iff (!rst_n)
        state == RUN |-> fa_sum == (fa_a ^ fa_b ^ fa_cin));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0, sum;
    logic fa_a, fa_b, fa_cin, fa_sum, fa_carry;
    logic out_valid, out_ready = 1'b0, cout, busy;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf;
`endif
    int n_chk = 0, n_fail = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_carry(fa_carry), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef SERIAL_ADD_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_cin & (fa_a | fa_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic carry_into(input longint unsigned x, input longint unsigned y,
                                        input logic c, input int i);
        longint unsigned m;
        m = (64'd1 << i) - 1;
        return 1'(((x & m) + (y & m) + c) >> i);
    endfunction

    function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
    endfunction

    // one full transaction with per-cycle RUN checks and optional DONE backpressure
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input int hold);
        longint unsigned full;
        full = longint'(ta) + longint'(tb_v) + longint'(tc);
        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        check("accept_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("run_in_ready", in_ready, 1'b0);
            check("run_out_valid", out_valid, 1'b0);
            check("run_fa_a", fa_a, ta[i]);
            check("run_fa_b", fa_b, tb_v[i]);
            check("run_fa_cin", fa_cin, carry_into(longint'(ta), longint'(tb_v), tc, i));
            tick();
        end
        check("done_valid", out_valid, 1'b1);
        check("done_in_ready", in_ready, 1'b0);
        check("done_busy", busy, 1'b1);
        check("done_sum", sum, full[W-1:0]);
        check("done_cout", cout, full[W]);
`ifdef SERIAL_ADD_OVF_EN
        check("done_ovf", ovf, signed_ovf(ta, tb_v, tc));
`endif
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (h == 2) begin
                in_valid = 1'b1; a = 8'h11;
            end
            check("hold_in_ready", in_ready, 1'b0);
            tick();
            in_valid = 1'b0; a = '0;
            check("hold_valid", out_valid, 1'b1);
            check("hold_sum", sum, full[W-1:0]);
            check("hold_cout", cout, full[W]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_sum_held", sum, full[W-1:0]);
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] exp_v;
        int done_ops, cycles;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 3'b000);
        rst_n = 1'b1;
        tick();
        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h00, 8'h00, 1'b1, 0);
`ifdef SERIAL_ADD_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'hFF, 1'b0, 0);
        run_op(8'h05, 8'h03, 1'b0, 0);
`endif
        run_op(8'hC3, 8'h5A, 1'b1, 5);
        // abort mid-RUN with reset; cout is 1 from the previous op so clearing is visible
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_sum", sum, '0);
        check("abort_cout", cout, 1'b0);
        run_op(8'h03, 8'h04, 1'b0, 0);
        // random traffic against a scoreboard of a+b+cin
        done_ops = 0;
        cycles = 0;
        while (done_ops < 500 && cycles < 40000) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            if (in_valid && in_ready) q.push_back((W + 1)'(a) + (W + 1)'(b) + (W + 1)'(cin));
            if (out_valid && out_ready) begin
                check("rand_queue_nonempty", q.size() > 0, 1'b1);
                exp_v = (q.size() > 0) ? q.pop_front() : '0;
                check("rand_result", {cout, sum}, exp_v);
                done_ops++;
            end
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rand_completed", done_ops, 500);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
